booth_ctrl: RTL

Control unit for the 8-bit radix-2 Booth multiplier datapath. It captures two operands on a start request and drives them onto the shared datapath bus in sequence (multiplicand, multiplier, iteration count). It then steps the add/subtract/arithmetic-shift loop from the datapath status bits Q0, q10 and count. It asserts done while the datapath's {A,Q} product output is valid.

---
 rtl/booth_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing FSM for an N-bit radix-2 Booth multiplier datapath.
// Captures operands on start, loads M, Q and Count over the shared data bus,
// then walks the add/subtract/shift loop until the Count register runs out.
module booth_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    input  logic         Q0,
    input  logic         q10,
    input  logic [N-1:0] count,
    output logic [N-1:0] data,
    output logic         LdM,
    output logic         LdQ,
    output logic         LdA,
    output logic         Ld_Count,
    output logic         Ldq1,
    output logic         resetM,
    output logic         resetQ,
    output logic         resetA,
    output logic         reset_Count,
    output logic         resetq1,
    output logic         shift,
    output logic         ctrl,
    output logic         dec,
    output logic         done,
    output logic         busy
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        LOAD_CNT,
        CHECK,
        ADD,
        SUB,
        SHIFT,
        DONE
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [N-1:0] m_reg;
    logic [N-1:0] q_reg;
    logic         accept;

    // A new request is only honoured while the controller is not sequencing.
    assign accept = start && (state == IDLE || state == DONE);

    // State register plus operand capture, so later input changes cannot disturb a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            m_reg <= '0;
            q_reg <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                m_reg <= multiplicand;
                q_reg <= multiplier;
            end
        end
    end

    // Moore output decode and next-state selection; reset forces the datapath clears.
    always_comb begin
        next_state  = state;
        data        = '0;
        LdM         = 1'b0;
        LdQ         = 1'b0;
        LdA         = 1'b0;
        Ld_Count    = 1'b0;
        Ldq1        = 1'b0;
        resetM      = 1'b0;
        resetQ      = 1'b0;
        resetA      = 1'b0;
        reset_Count = 1'b0;
        resetq1     = 1'b0;
        shift       = 1'b0;
        ctrl        = 1'b0;
        dec         = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;

        if (reset) begin
            resetM      = 1'b1;
            resetQ      = 1'b1;
            resetA      = 1'b1;
            reset_Count = 1'b1;
            resetq1     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) next_state = LOAD_M;
                end
                LOAD_M: begin
                    busy       = 1'b1;
                    data       = m_reg;
                    LdM        = 1'b1;
                    next_state = LOAD_Q;
                end
                LOAD_Q: begin
                    busy       = 1'b1;
                    data       = q_reg;
                    LdQ        = 1'b1;
                    resetA     = 1'b1;
                    resetq1    = 1'b1;
                    next_state = LOAD_CNT;
                end
                LOAD_CNT: begin
                    busy       = 1'b1;
                    data       = N'(N);
                    Ld_Count   = 1'b1;
                    next_state = CHECK;
                end
                CHECK: begin
                    busy = 1'b1;
                    if (count == '0) begin
                        next_state = DONE;
                    end else begin
                        case ({Q0, q10})
                            2'b10:   next_state = SUB;
                            2'b01:   next_state = ADD;
                            default: next_state = SHIFT;
                        endcase
                    end
                end
                ADD: begin
                    busy       = 1'b1;
                    LdA        = 1'b1;
                    ctrl       = 1'b0;
                    next_state = SHIFT;
                end
                SUB: begin
                    busy       = 1'b1;
                    LdA        = 1'b1;
                    ctrl       = 1'b1;
                    next_state = SHIFT;
                end
                SHIFT: begin
                    busy  = 1'b1;
                    shift = 1'b1;
                    Ldq1  = 1'b1;
                    dec   = 1'b1;
                    if (count == N'(1)) next_state = DONE;
                    else                next_state = CHECK;
                end
                DONE: begin
                    done = 1'b1;
                    if (start) next_state = LOAD_M;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule
